// File: rtl/conflict_free_memory_unmap.sv
// Inverse conflict-free bank map: recovers 8 original coefficient indices from
// (bank, row) pairs, flags bank collisions, and buffers groups in a 2-entry FIFO.
module conflict_free_memory_unmap #(
    parameter int ROW_W  = 7,
    parameter int BANK_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [8*BANK_W-1:0]               bank_in,
    input  logic [8*ROW_W-1:0]                row_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [8*(ROW_W+BANK_W)-1:0]       old_address_out,
    output logic                              out_conflict,
    input  logic                              clr_count,
    output logic [CNT_W-1:0]                  conflict_count
);

    localparam int LANES   = 8;
    localparam int ADDR_W  = ROW_W + BANK_W;
    localparam int GROUP_W = LANES * ADDR_W;

    function automatic logic row_parity(input logic [ROW_W-1:0] row);
        return ^row;
    endfunction

    // The forward map flips the bank MSB on odd row parity; flipping it back undoes that.
    function automatic logic [ADDR_W-1:0] unmap_lane(input logic [BANK_W-1:0] bank,
                                                    input logic [ROW_W-1:0]  row);
        logic [ADDR_W-1:0] old;
        old = {row, bank};
        old[BANK_W-1] = bank[BANK_W-1] ^ row_parity(row);
        return old;
    endfunction

    function automatic logic bank_collision(input logic [LANES*BANK_W-1:0] banks);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (banks[i*BANK_W +: BANK_W] == banks[j*BANK_W +: BANK_W]) begin
                    hit = 1'b1;
                end else begin
                    hit = hit;
                end
            end
        end
        return hit;
    endfunction

    logic [GROUP_W-1:0] unmapped_s;
    logic               conflict_s;
    logic               push_s;
    logic               pop_s;
    logic               in_ready_s;
    logic               out_valid_s;

    logic [1:0]         cnt_r;
    logic [GROUP_W-1:0] head_addr_r;
    logic               head_conf_r;
    logic [GROUP_W-1:0] tail_addr_r;
    logic               tail_conf_r;
    logic [CNT_W-1:0]   count_r;

    // Per-lane inverse map and collision flag for the group on the input.
    always_comb begin
        unmapped_s = '0;
        for (int l = 0; l < LANES; l++) begin
            unmapped_s[l*ADDR_W +: ADDR_W] = unmap_lane(bank_in[l*BANK_W +: BANK_W],
                                                        row_in[l*ROW_W +: ROW_W]);
        end
        conflict_s = bank_collision(bank_in);
    end

    // Handshake qualifiers derived from occupancy only.
    always_comb begin
        in_ready_s  = (cnt_r < 2'd2);
        out_valid_s = (cnt_r != 2'd0);
        push_s      = in_valid & in_ready_s;
        pop_s       = out_valid_s & out_ready;
    end

    // Two-entry buffer kept as head/tail registers so the outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= 2'd0;
            head_addr_r <= '0;
            head_conf_r <= 1'b0;
            tail_addr_r <= '0;
            tail_conf_r <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    cnt_r <= cnt_r + 2'd1;
                    if (cnt_r == 2'd0) begin
                        head_addr_r <= unmapped_s;
                        head_conf_r <= conflict_s;
                    end else begin
                        tail_addr_r <= unmapped_s;
                        tail_conf_r <= conflict_s;
                    end
                end
                2'b01: begin
                    cnt_r       <= cnt_r - 2'd1;
                    head_addr_r <= tail_addr_r;
                    head_conf_r <= tail_conf_r;
                end
                // Push with pop only happens at one entry: the new group becomes head.
                2'b11: begin
                    head_addr_r <= unmapped_s;
                    head_conf_r <= conflict_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Saturating collision counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr_count) begin
            count_r <= '0;
        end else if (push_s && conflict_s && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_s;
    assign old_address_out = head_addr_r;
    assign out_conflict    = head_conf_r;
    assign conflict_count  = count_r;

endmodule
